dram_read_arbiter: RTL and testbench
====================================

DRAM_READ_ARBITER -- requirements
Module: dram_read_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 1024, max clk cycles in ISSUE before abort; SYNC_STAGES, 2, busy synchronizer depth.
REQ-002 clk  in  1  sole clock; every port below is synchronous to clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 r0_kick, r1_kick  in  1  per-requester read request, held high until that requester's busy is seen.
REQ-005 r0_num, r1_num  in  32  words to read; r0_addr, r1_addr  in  32  DRAM byte address.
REQ-006 r0_busy, r1_busy  out  1  per-requester busy, same semantics as the DRAM reader busy.
REQ-007 r0_we, r1_we  out  1  returned-word strobe, steered to the owner.
REQ-008 kick  out  1; read_num  out  32; read_addr  out  32: command to the DRAM reader.
REQ-009 busy  in  1  DRAM reader busy, asynchronous to the command path; buf_we  in  1  returned-word strobe.
REQ-010 owner  out  1  current grantee; grant_valid  out  1  high when state != IDLE.
REQ-011 err_timeout, err_count, err_stray  out  1  sticky error flags.

Function
REQ-012 busy SHALL pass through a SYNC_STAGES-flop synchronizer; busy_s denotes its output.
REQ-013 States SHALL be IDLE, ISSUE, XFER, DONE.
REQ-014 IDLE: if any rN_kick is high, pick a grantee, latch its addr/num into read_addr/read_num, set owner, clear word counter, and enter ISSUE the next cycle.
REQ-015 Both kicks high in IDLE: grant the requester that is not the last completed owner (round-robin); after reset r0 wins.
REQ-016 kick SHALL equal (state == ISSUE), with no other qualifier.
REQ-017 ISSUE: busy_s=1 -> XFER. Timeout counter reaching TIMEOUT-1 -> set err_timeout and go to IDLE without updating the rr pointer.
REQ-018 XFER: busy_s=0 -> DONE.
REQ-019 DONE: one cycle only; if word count != read_num, set err_count; update the rr pointer to owner; -> IDLE.
REQ-020 rN_busy SHALL be (state != IDLE && owner == N); a non-owner sees 0.
REQ-021 rN_we SHALL be buf_we && grant_valid && owner == N, combinational, zero latency.
REQ-022 buf_we while IDLE SHALL set err_stray and be dropped.
REQ-023 Word counter: 32-bit, increments on every steered buf_we including the cycle busy_s falls, saturates at 2^32-1.
REQ-024 rN_kick deasserting after capture SHALL NOT abort; the latched command completes.
REQ-025 rN_kick, num and addr SHALL be ignored in ISSUE, XFER and DONE; sampling happens in IDLE only.
REQ-026 read_addr and read_num SHALL stay stable from capture until the next capture.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, kick 0, read_num/read_addr 0, owner 0, rr pointer favouring r0, all busy/we outputs 0, counters 0, all err flags 0.
REQ-028 Reset mid-transfer SHALL NOT signal the DRAM reader; words arriving after release while IDLE set err_stray.
REQ-029 Error flags SHALL clear only on reset.

Structure
REQ-030 Package dram_arb_pkg SHALL hold the state encoding, requester count (2), the 32-bit address/count width and the TIMEOUT default.
REQ-031 The busy synchronizer SHALL be the sub-module bit_sync (parameter STAGES); all other logic stays in dram_read_arbiter.

Verification
REQ-032 Single request: r0_kick with addr 0x100_0000 and num 64; DRAM model asserts busy for 70 cycles with 64 buf_we -> kick drops after busy_s; 64 r0_we; r0_busy falls one cycle after DONE; no err.
REQ-033 Contention: r0_kick and r1_kick high together, repeated for 4 transactions -> grants r0, r1, r0, r1; the non-owner busy stays 0 while the other is served.
REQ-034 Timeout: TIMEOUT=16, busy never rises -> kick high for exactly 16 cycles, err_timeout=1, back to IDLE; the next request is granted normally.
REQ-035 Short transfer: num 64, only 60 buf_we -> err_count=1 in the DONE cycle; buf_we pulsed while IDLE -> err_stray=1 and no rN_we.
REQ-036 Reset mid-XFER after 20 words -> all outputs at reset values asynchronously; 44 trailing buf_we set err_stray only after rst_n release.
REQ-037 Kick withdrawn: r1_kick pulsed for 1 cycle in IDLE -> command still issued and completed with the latched addr/num.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-requester DRAM read arbiter.
package dram_arb_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef logic [ADDR_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM reader between two requesters.
module dram_read_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_kick,
  input  logic [31:0] r0_num,
  input  logic [31:0] r0_addr,
  input  logic        r1_kick,
  input  logic [31:0] r1_num,
  input  logic [31:0] r1_addr,
  output logic        r0_busy,
  output logic        r1_busy,
  output logic        r0_we,
  output logic        r1_we,
  output logic        kick,
  output logic [31:0] read_num,
  output logic [31:0] read_addr,
  input  logic        busy,
  input  logic        buf_we,
  output logic        owner,
  output logic        grant_valid,
  output logic        err_timeout,
  output logic        err_count,
  output logic        err_stray
);

  state_t               state, state_nxt;
  logic                 busy_s;
  logic [NUM_REQ-1:0]   req;
  logic                 capture;
  logic                 grant_sel;
  logic                 tmo_hit;
  logic                 rr_last;
  logic                 word_inc;
  word_t                word_cnt, word_cnt_nxt;
  word_t                tmo_cnt;

  bit_sync #(.STAGES(SYNC_STAGES)) u_busy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (busy),
    .q     (busy_s)
  );

  assign req = {r1_kick, r0_kick};

  // Next-state logic; grant choice favours whoever did not finish last.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    grant_sel = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          capture   = 1'b1;
          grant_sel = (&req) ? ~rr_last : req[1];
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (busy_s) begin
          state_nxt = XFER;
        end else if (tmo_cnt == word_t'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (!busy_s) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign grant_valid  = (state != IDLE);
  assign kick         = (state == ISSUE);
  assign r0_busy      = grant_valid && !owner;
  assign r1_busy      = grant_valid &&  owner;
  assign r0_we        = buf_we && grant_valid && !owner;
  assign r1_we        = buf_we && grant_valid &&  owner;
  assign word_inc     = buf_we && grant_valid;
  assign word_cnt_nxt = (word_inc && (word_cnt != '1)) ? word_cnt + 1'b1 : word_cnt;

  // Command capture: only sampled in IDLE, held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_addr <= '0;
      read_num  <= '0;
      owner     <= 1'b0;
    end else if (capture) begin
      read_addr <= grant_sel ? r1_addr : r0_addr;
      read_num  <= grant_sel ? r1_num  : r0_num;
      owner     <= grant_sel;
    end
  end

  // Saturating word counter and ISSUE timeout counter, cleared on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (capture) begin
      word_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      word_cnt <= word_cnt_nxt;
      if (state == ISSUE) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Round-robin pointer moves only on a completed transfer, not a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_last <= 1'b1;
    else if (state == DONE)  rr_last <= owner;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      err_count   <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      if (tmo_hit) err_timeout <= 1'b1;
      if ((state == DONE) && (word_cnt_nxt != read_num)) err_count <= 1'b1;
      if (buf_we && (state == IDLE)) err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Scoreboard bench for dram_read_arbiter with a simple DRAM reader model.
module tb_dram_read_arbiter;

  logic        clk, rst_n;
  logic        r0_kick, r1_kick;
  logic [31:0] r0_num, r0_addr, r1_num, r1_addr;
  logic        r0_busy, r1_busy, r0_we, r1_we;
  logic        kick;
  logic [31:0] read_num, read_addr;
  logic        busy, buf_we;
  logic        owner, grant_valid;
  logic        err_timeout, err_count, err_stray;

  dram_read_arbiter #(.TIMEOUT(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_kick(r0_kick), .r0_num(r0_num), .r0_addr(r0_addr),
    .r1_kick(r1_kick), .r1_num(r1_num), .r1_addr(r1_addr),
    .r0_busy(r0_busy), .r1_busy(r1_busy), .r0_we(r0_we), .r1_we(r1_we),
    .kick(kick), .read_num(read_num), .read_addr(read_addr),
    .busy(busy), .buf_we(buf_we),
    .owner(owner), .grant_valid(grant_valid),
    .err_timeout(err_timeout), .err_count(err_count), .err_stray(err_stray)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        own;
    logic [31:0] addr;
    logic [31:0] num;
    int          words;     // -1: not checked
    int          kick_len;  // -1: not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic push(input logic own, input logic [31:0] addr, input logic [31:0] num,
                      input int words, input int kick_len);
    exp_t e;
    e.own = own; e.addr = addr; e.num = num; e.words = words; e.kick_len = kick_len;
    exp_q.push_back(e);
  endtask

  // DRAM reader model
  int dram_busy  = 70;
  int dram_words = 64;
  bit dram_en    = 1'b1;

  initial begin
    busy   = 1'b0;
    buf_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (kick && dram_en) begin
        repeat (2) begin @(posedge clk); #1; end
        busy = 1'b1;
        for (int i = 0; i < dram_busy; i++) begin
          buf_we = (i < dram_words);
          @(posedge clk); #1;
        end
        buf_we = 1'b0;
        busy   = 1'b0;
      end
    end
  end

  // Monitor: pops an expectation at every grant and checks it when the grant ends
  exp_t cur;
  bit   in_txn = 1'b0;
  bit   prev_gv = 1'b0;
  int   mon_wcnt = 0;
  int   mon_bad  = 0;
  int   mon_kick = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (grant_valid && !prev_gv) begin
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_grant");
        end else begin
          cur      = exp_q.pop_front();
          in_txn   = 1'b1;
          mon_wcnt = 0;
          mon_bad  = 0;
          mon_kick = 0;
          chk("grant_owner", 32'(owner), 32'(cur.own));
          chk("grant_addr", read_addr, cur.addr);
          chk("grant_num", read_num, cur.num);
        end
      end
      if (grant_valid && in_txn) begin
        if (kick) mon_kick++;
        if (!cur.own) begin
          if (r0_we) mon_wcnt++;
          if (r1_we || r1_busy || !r0_busy) mon_bad++;
        end else begin
          if (r1_we) mon_wcnt++;
          if (r0_we || r0_busy || !r1_busy) mon_bad++;
        end
      end
      if (!grant_valid && prev_gv && in_txn) begin
        in_txn = 1'b0;
        chk("nonowner_quiet", 32'(mon_bad), 32'd0);
        if (cur.words >= 0) begin
          chk("word_count", 32'(mon_wcnt), 32'(cur.words));
          chk("addr_stable", read_addr, cur.addr);
          chk("num_stable", read_num, cur.num);
        end
        if (cur.kick_len >= 0) chk("kick_len", 32'(mon_kick), 32'(cur.kick_len));
      end
      prev_gv = grant_valid;
    end
  end

  task automatic wait_busy(input bit which, input int budget, input string name);
    int n = 0;
    while ((which ? r1_busy : r0_busy) !== 1'b1) begin
      if (n >= budget) begin bound_fail(name); return; end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin bound_fail(name); return; end
    end while (grant_valid !== 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    r0_kick = 1'b0; r1_kick = 1'b0;
    r0_num  = '0;   r0_addr = '0;
    r1_num  = '0;   r1_addr = '0;
    #1;
    chk("rst_kick", 32'(kick), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_read_addr", read_addr, 32'd0);
    chk("rst_read_num", read_num, 32'd0);
    chk("rst_busy_out", 32'({r0_busy, r1_busy, grant_valid}), 32'd0);
    chk("rst_errs", 32'({err_timeout, err_count, err_stray}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: 4 transactions, expect r0, r1, r0, r1
    dram_busy = 10; dram_words = 8;
    for (int round = 0; round < 2; round++) begin
      r0_addr = 32'h0000_1000 + 32'(round); r0_num = 32'd8;
      r1_addr = 32'h0000_2000 + 32'(round); r1_num = 32'd8;
      push(1'b0, r0_addr, 32'd8, 8, -1);
      push(1'b1, r1_addr, 32'd8, 8, -1);
      r0_kick = 1'b1; r1_kick = 1'b1;
      wait_busy(1'b0, 20, "wait_r0_busy_cont");
      r0_kick = 1'b0;
      wait_busy(1'b1, 200, "wait_r1_busy_cont");
      r1_kick = 1'b0;
      wait_idle(200, "wait_idle_cont");
    end
    chk("cont_errs", 32'({err_timeout, err_count, err_stray}), 32'd0);

    // Single request on r0
    dram_busy = 70; dram_words = 64;
    r0_addr = 32'h0100_0000; r0_num = 32'd64;
    push(1'b0, 32'h0100_0000, 32'd64, 64, -1);
    r0_kick = 1'b1;
    wait_busy(1'b0, 20, "wait_r0_busy_single");
    r0_kick = 1'b0;
    wait_idle(300, "wait_idle_single");
    chk("single_errs", 32'({err_timeout, err_count, err_stray}), 32'd0);

    // Timeout: reader never answers, kick must last exactly TIMEOUT cycles
    dram_en = 1'b0;
    r1_addr = 32'h0000_3000; r1_num = 32'd5;
    push(1'b1, 32'h0000_3000, 32'd5, 0, 16);
    r1_kick = 1'b1;
    wait_busy(1'b1, 20, "wait_r1_busy_tmo");
    r1_kick = 1'b0;
    wait_idle(100, "wait_idle_tmo");
    chk("tmo_err_timeout", 32'(err_timeout), 32'd1);
    chk("tmo_err_count", 32'(err_count), 32'd0);
    dram_en = 1'b1;

    // Timeout left the rr pointer on r0, so contention now grants r1 first
    dram_busy = 10; dram_words = 8;
    r0_addr = 32'h0000_4000; r0_num = 32'd8;
    r1_addr = 32'h0000_5000; r1_num = 32'd8;
    push(1'b1, 32'h0000_5000, 32'd8, 8, -1);
    push(1'b0, 32'h0000_4000, 32'd8, 8, -1);
    r0_kick = 1'b1; r1_kick = 1'b1;
    wait_busy(1'b1, 20, "wait_r1_busy_post_tmo");
    r1_kick = 1'b0;
    wait_busy(1'b0, 200, "wait_r0_busy_post_tmo");
    r0_kick = 1'b0;
    wait_idle(200, "wait_idle_post_tmo");
    chk("post_tmo_err_count", 32'(err_count), 32'd0);

    // Short transfer: 60 of 64 words
    dram_busy = 70; dram_words = 60;
    r0_addr = 32'h0000_6000; r0_num = 32'd64;
    push(1'b0, 32'h0000_6000, 32'd64, 60, -1);
    r0_kick = 1'b1;
    wait_busy(1'b0, 20, "wait_r0_busy_short");
    r0_kick = 1'b0;
    wait_idle(300, "wait_idle_short");
    chk("short_err_count", 32'(err_count), 32'd1);
    chk("short_err_stray", 32'(err_stray), 32'd0);

    // Stray word while IDLE
    @(posedge clk); #1;
    buf_we = 1'b1;
    #1;
    chk("stray_no_we", 32'({r0_we, r1_we}), 32'd0);
    @(posedge clk); #1;
    buf_we = 1'b0;
    chk("stray_err", 32'(err_stray), 32'd1);
    chk("stray_err_count_sticky", 32'(err_count), 32'd1);

    // Reset mid-transfer after 20 words
    dram_busy = 70; dram_words = 64;
    r0_addr = 32'h0000_7000; r0_num = 32'd64;
    push(1'b0, 32'h0000_7000, 32'd64, -1, -1);
    r0_kick = 1'b1;
    wait_busy(1'b0, 20, "wait_r0_busy_rst");
    r0_kick = 1'b0;
    begin
      int n = 0;
      while (mon_wcnt < 20 || !in_txn) begin
        if (n > 200) begin bound_fail("wait_20_words"); break; end
        @(negedge clk);
        n++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'({kick, grant_valid, r0_busy, r1_busy}), 32'd0);
    chk("midrst_we", 32'({r0_we, r1_we}), 32'd0);
    chk("midrst_addr_num", read_addr | read_num, 32'd0);
    chk("midrst_errs", 32'({err_timeout, err_count, err_stray}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_held_stray", 32'(err_stray), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_trailing_word", 32'(buf_we), 32'd1);
    chk("post_rst_no_we", 32'({r0_we, r1_we}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_stray", 32'(err_stray), 32'd1);
    begin
      int n = 0;
      while (busy !== 1'b0) begin
        if (n > 100) begin bound_fail("wait_busy_drop"); break; end
        @(posedge clk); #1;
        n++;
      end
    end
    chk("post_rst_no_kick", 32'(grant_valid), 32'd0);

    // Kick withdrawn after one cycle: latched command still completes
    repeat (4) @(posedge clk);
    #1;
    dram_busy = 10; dram_words = 8;
    r1_addr = 32'h0000_ABC0; r1_num = 32'd8;
    push(1'b1, 32'h0000_ABC0, 32'd8, 8, -1);
    r1_kick = 1'b1;
    @(posedge clk); #1;
    r1_kick = 1'b0;
    r1_addr = 32'hDEAD_BEEF; r1_num = 32'd99;
    wait_idle(200, "wait_idle_withdrawn");
    chk("withdrawn_err_count", 32'(err_count), 32'd0);
    chk("withdrawn_err_timeout", 32'(err_timeout), 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
